sprite_frame_rasterizer: RTL and testbench

Parametrised successor to the single-object draw path: it snapshots the position, size, colour and enable of up to NUM_OBJ in-game objects on a frame request, then rasterizes each enabled rectangle in index order. Output is one registered pixel per cycle to the VGA adapter, off-screen pixels are suppressed, and the frame completion is signalled back to the game FSM. It sits between the game-state registers and the VGA adapter, replacing the external per-object control sequencing.

---
 rtl/sprite_frame_rasterizer_pkg.sv | 21 ++
 rtl/sprite_frame_rasterizer_rect_raster.sv | 69 ++++++
 rtl/sprite_frame_rasterizer.sv | 254 +++++++++++++++++++++++++
 tb/tb_sprite_frame_rasterizer.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_frame_rasterizer_pkg.sv
// Shared state encoding, background colour and sizing helpers for the
// sprite frame rasterizer and its rectangle walker.
package sprite_draw_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    DRAW   = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam logic [2:0] BG_COLOUR    = 3'b000;
  localparam int         DEF_SCREEN_W = 160;
  localparam int         DEF_SCREEN_H = 120;

  // Width of a slot index counter; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sprite_frame_rasterizer_rect_raster.sv
// Row-major walk over one rectangle: pixel coordinate, on-screen test and
// last-pixel flag. Coordinates wrap modulo the coordinate width.
module rect_raster
  import sprite_draw_pkg::*;
#(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int DIM_W    = 5,
  parameter int COL_W    = 3,
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic             step_i,
  input  logic [X_W-1:0]   base_x_i,
  input  logic [Y_W-1:0]   base_y_i,
  input  logic [DIM_W-1:0] w_i,
  input  logic [DIM_W-1:0] h_i,
  input  logic [COL_W-1:0] colour_i,
  output logic [X_W-1:0]   px_o,
  output logic [Y_W-1:0]   py_o,
  output logic [COL_W-1:0] pc_o,
  output logic             vis_o,
  output logic             last_o
);

  localparam logic [DIM_W-1:0] DIM_ONE = DIM_W'(1);

  logic [DIM_W-1:0] col_q, col_d;
  logic [DIM_W-1:0] row_q, row_d;
  logic             col_end;

  assign col_end = (col_q == w_i - DIM_ONE);

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (start_i) begin
      col_d = '0;
      row_d = '0;
    end else if (step_i) begin
      if (col_end) begin
        col_d = '0;
        row_d = row_q + DIM_ONE;
      end else begin
        col_d = col_q + DIM_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign px_o   = base_x_i + X_W'(col_q);
  assign py_o   = base_y_i + Y_W'(row_q);
  assign pc_o   = colour_i;
  assign vis_o  = (int'(px_o) < SCREEN_W) && (int'(py_o) < SCREEN_H);
  assign last_o = col_end && (row_q == h_i - DIM_ONE);

endmodule

// File: rtl/sprite_frame_rasterizer.sv
// Snapshots all object slots on frame_start and rasterizes enabled rectangles
// in slot order, one registered pixel per cycle. Optional ERASE_PASS_EN.
module sprite_frame_rasterizer
  import sprite_draw_pkg::*;
#(
  parameter int NUM_OBJ  = 5,
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int DIM_W    = 5,
  parameter int COL_W    = 3,
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     frame_start,
  input  logic [NUM_OBJ*X_W-1:0]   obj_x,
  input  logic [NUM_OBJ*Y_W-1:0]   obj_y,
  input  logic [NUM_OBJ*DIM_W-1:0] obj_w,
  input  logic [NUM_OBJ*DIM_W-1:0] obj_h,
  input  logic [NUM_OBJ*COL_W-1:0] obj_c,
  input  logic [NUM_OBJ-1:0]       obj_en,
  output logic [X_W-1:0]           vga_x,
  output logic [Y_W-1:0]           vga_y,
  output logic [COL_W-1:0]         vga_c,
  output logic                     vga_plot,
  output logic                     busy,
  output logic                     frame_done
);

  localparam int                 IDX_W    = idx_width(NUM_OBJ);
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_OBJ - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  logic [NUM_OBJ*X_W-1:0]   sx_q;
  logic [NUM_OBJ*Y_W-1:0]   sy_q;
  logic [NUM_OBJ*DIM_W-1:0] sw_q, sh_q;
  logic [NUM_OBJ*COL_W-1:0] sc_q;
  logic [NUM_OBJ-1:0]       sen_q;

  logic [X_W-1:0]   sel_x;
  logic [Y_W-1:0]   sel_y;
  logic [DIM_W-1:0] sel_w, sel_h;
  logic [COL_W-1:0] sel_c;
  logic             sel_en;

  logic             slot_live, adv;
  logic             rr_start, rr_step, rr_vis, rr_last;
  logic [X_W-1:0]   rr_px;
  logic [Y_W-1:0]   rr_py;
  logic [COL_W-1:0] rr_pc;

  logic [X_W-1:0]   vga_x_q;
  logic [Y_W-1:0]   vga_y_q;
  logic [COL_W-1:0] vga_c_q;
  logic             plot_q, busy_q, done_q;

`ifdef ERASE_PASS_EN
  logic [NUM_OBJ*X_W-1:0]   prev_x_q;
  logic [NUM_OBJ*Y_W-1:0]   prev_y_q;
  logic [NUM_OBJ*DIM_W-1:0] prev_w_q, prev_h_q;
  logic [NUM_OBJ-1:0]       prev_en_q;
  logic                     prev_vld_q, erase_q, erase_d;

  // The erase sweep walks last frame's geometry in the background colour.
  always_comb begin
    if (erase_q) begin
      sel_x  = prev_x_q[int'(idx_q)*X_W +: X_W];
      sel_y  = prev_y_q[int'(idx_q)*Y_W +: Y_W];
      sel_w  = prev_w_q[int'(idx_q)*DIM_W +: DIM_W];
      sel_h  = prev_h_q[int'(idx_q)*DIM_W +: DIM_W];
      sel_c  = COL_W'(BG_COLOUR);
      sel_en = prev_en_q[idx_q];
    end else begin
      sel_x  = sx_q[int'(idx_q)*X_W +: X_W];
      sel_y  = sy_q[int'(idx_q)*Y_W +: Y_W];
      sel_w  = sw_q[int'(idx_q)*DIM_W +: DIM_W];
      sel_h  = sh_q[int'(idx_q)*DIM_W +: DIM_W];
      sel_c  = sc_q[int'(idx_q)*COL_W +: COL_W];
      sel_en = sen_q[idx_q];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      prev_x_q   <= '0;
      prev_y_q   <= '0;
      prev_w_q   <= '0;
      prev_h_q   <= '0;
      prev_en_q  <= '0;
      prev_vld_q <= 1'b0;
      erase_q    <= 1'b0;
    end else begin
      erase_q <= erase_d;
      if (state_q == DONE) begin
        prev_x_q   <= sx_q;
        prev_y_q   <= sy_q;
        prev_w_q   <= sw_q;
        prev_h_q   <= sh_q;
        prev_en_q  <= sen_q;
        prev_vld_q <= 1'b1;
      end
    end
  end
`else
  always_comb begin
    sel_x  = sx_q[int'(idx_q)*X_W +: X_W];
    sel_y  = sy_q[int'(idx_q)*Y_W +: Y_W];
    sel_w  = sw_q[int'(idx_q)*DIM_W +: DIM_W];
    sel_h  = sh_q[int'(idx_q)*DIM_W +: DIM_W];
    sel_c  = sc_q[int'(idx_q)*COL_W +: COL_W];
    sel_en = sen_q[idx_q];
  end
`endif

  assign slot_live = sel_en && (sel_w != '0) && (sel_h != '0);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    rr_start = 1'b0;
    rr_step  = 1'b0;
    adv      = 1'b0;
`ifdef ERASE_PASS_EN
    erase_d  = erase_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (frame_start) begin
          state_d = SELECT;
          idx_d   = '0;
`ifdef ERASE_PASS_EN
          erase_d = prev_vld_q;
`endif
        end
      end
      SELECT: begin
        if (slot_live) begin
          rr_start = 1'b1;
          state_d  = DRAW;
        end else begin
          adv = 1'b1;
        end
      end
      DRAW: begin
        rr_step = 1'b1;
        adv     = rr_last;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Move to the next slot, the draw sweep after an erase sweep, or finish.
    if (adv) begin
      if (idx_q != LAST_IDX) begin
        idx_d   = idx_q + IDX_W'(1);
        state_d = SELECT;
      end
`ifdef ERASE_PASS_EN
      else if (erase_q) begin
        erase_d = 1'b0;
        idx_d   = '0;
        state_d = SELECT;
      end
`endif
      else begin
        state_d = DONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sx_q  <= '0;
      sy_q  <= '0;
      sw_q  <= '0;
      sh_q  <= '0;
      sc_q  <= '0;
      sen_q <= '0;
    end else if ((state_q == IDLE) && frame_start) begin
      sx_q  <= obj_x;
      sy_q  <= obj_y;
      sw_q  <= obj_w;
      sh_q  <= obj_h;
      sc_q  <= obj_c;
      sen_q <= obj_en;
    end
  end

  rect_raster #(
    .X_W     (X_W),
    .Y_W     (Y_W),
    .DIM_W   (DIM_W),
    .COL_W   (COL_W),
    .SCREEN_W(SCREEN_W),
    .SCREEN_H(SCREEN_H)
  ) u_rect (
    .clk     (clk),
    .reset   (reset),
    .start_i (rr_start),
    .step_i  (rr_step),
    .base_x_i(sel_x),
    .base_y_i(sel_y),
    .w_i     (sel_w),
    .h_i     (sel_h),
    .colour_i(sel_c),
    .px_o    (rr_px),
    .py_o    (rr_py),
    .pc_o    (rr_pc),
    .vis_o   (rr_vis),
    .last_o  (rr_last)
  );

  // Pixel coordinates hold their last plotted value between strobes.
  always_ff @(posedge clk) begin
    if (!reset) begin
      vga_x_q <= '0;
      vga_y_q <= '0;
      vga_c_q <= '0;
      plot_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      busy_q <= (state_d != IDLE);
      done_q <= (state_d == DONE);
      plot_q <= (state_q == DRAW) && rr_vis;
      if ((state_q == DRAW) && rr_vis) begin
        vga_x_q <= rr_px;
        vga_y_q <= rr_py;
        vga_c_q <= rr_pc;
      end
    end
  end

  assign vga_x      = vga_x_q;
  assign vga_y      = vga_y_q;
  assign vga_c      = vga_c_q;
  assign vga_plot   = plot_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_sprite_frame_rasterizer.sv
// Self-checking bench: a frame-level pixel model predicts every output cycle,
// plus directed frames with literal pixel lists and frame lengths.
module tb_sprite_frame_rasterizer;

  localparam int N  = 5;
  localparam int XW = 8;
  localparam int YW = 7;
  localparam int DW = 5;
  localparam int CW = 3;
  localparam int SW = 160;
  localparam int SH = 120;

  logic clk = 1'b0;
  logic reset, frame_start;
  logic [N*XW-1:0] obj_x;
  logic [N*YW-1:0] obj_y;
  logic [N*DW-1:0] obj_w, obj_h;
  logic [N*CW-1:0] obj_c;
  logic [N-1:0]    obj_en;
  logic [XW-1:0]   vga_x;
  logic [YW-1:0]   vga_y;
  logic [CW-1:0]   vga_c;
  logic            vga_plot, busy, frame_done;

  always #5 clk = ~clk;

  sprite_frame_rasterizer #(
    .NUM_OBJ(N), .X_W(XW), .Y_W(YW), .DIM_W(DW), .COL_W(CW),
    .SCREEN_W(SW), .SCREEN_H(SH)
  ) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start),
    .obj_x(obj_x), .obj_y(obj_y), .obj_w(obj_w), .obj_h(obj_h),
    .obj_c(obj_c), .obj_en(obj_en),
    .vga_x(vga_x), .vga_y(vga_y), .vga_c(vga_c), .vga_plot(vga_plot),
    .busy(busy), .frame_done(frame_done)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [N*XW-1:0] x;
    logic [N*YW-1:0] y;
    logic [N*DW-1:0] w;
    logic [N*DW-1:0] h;
    logic [N*CW-1:0] c;
    logic [N-1:0]    en;
  } snap_t;

  // kind: 0 = slot select cycle, 1 = pixel cycle, 2 = done cycle
  typedef struct { int kind; bit plot; int x; int y; int c; } cyc_t;
  typedef struct { bit plot; int x; int y; int c; bit busy; bit done; bit last; } ent_t;

  cyc_t  cyc_q[$];
  ent_t  sched[$];
  ent_t  e;
  snap_t cur_s;
`ifdef ERASE_PASS_EN
  snap_t prev_s;
  bit    prev_v = 1'b0;
`endif
  int ex_x = 0, ex_y = 0, ex_c = 0;
  bit ex_plot = 1'b0, ex_busy = 1'b0, ex_done = 1'b0;

  function automatic void add_sweep(input snap_t s, input bit erase);
    for (int i = 0; i < N; i++) begin
      int x, y, w, h, c;
      bit en;
      x  = int'(s.x[i*XW +: XW]);
      y  = int'(s.y[i*YW +: YW]);
      w  = int'(s.w[i*DW +: DW]);
      h  = int'(s.h[i*DW +: DW]);
      c  = int'(s.c[i*CW +: CW]);
      en = s.en[i];
      cyc_q.push_back('{kind: 0, plot: 1'b0, x: 0, y: 0, c: 0});
      if (en && w > 0 && h > 0) begin
        for (int r = 0; r < h; r++) begin
          for (int k = 0; k < w; k++) begin
            int px, py;
            px = (x + k) % (1 << XW);
            py = (y + r) % (1 << YW);
            cyc_q.push_back('{kind: 1, plot: (px < SW) && (py < SH),
                              x: px, y: py, c: (erase ? 0 : c)});
          end
        end
      end
    end
  endfunction

  // Outputs after the edge that ends cycle j of the frame.
  function automatic void build_sched();
    sched.delete();
    for (int j = 0; j < cyc_q.size(); j++) begin
      bit more, nxt_done;
      more     = (j + 1 < cyc_q.size());
      nxt_done = 1'b0;
      if (more) nxt_done = (cyc_q[j+1].kind == 2);
      sched.push_back('{plot: cyc_q[j].plot, x: cyc_q[j].x, y: cyc_q[j].y, c: cyc_q[j].c,
                        busy: more, done: nxt_done, last: !more});
    end
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      sched.delete();
      ex_plot = 1'b0; ex_x = 0; ex_y = 0; ex_c = 0;
      ex_busy = 1'b0; ex_done = 1'b0;
`ifdef ERASE_PASS_EN
      prev_v = 1'b0;
`endif
    end else if (sched.size() != 0) begin
      e = sched.pop_front();
      ex_plot = e.plot;
      if (e.plot) begin
        ex_x = e.x; ex_y = e.y; ex_c = e.c;
      end
      ex_busy = e.busy;
      ex_done = e.done;
`ifdef ERASE_PASS_EN
      if (e.last) begin
        prev_s = cur_s;
        prev_v = 1'b1;
      end
`endif
    end else if (frame_start) begin
      cur_s.x = obj_x; cur_s.y = obj_y; cur_s.w = obj_w;
      cur_s.h = obj_h; cur_s.c = obj_c; cur_s.en = obj_en;
      cyc_q.delete();
`ifdef ERASE_PASS_EN
      if (prev_v) add_sweep(prev_s, 1'b1);
`endif
      add_sweep(cur_s, 1'b0);
      cyc_q.push_back('{kind: 2, plot: 1'b0, x: 0, y: 0, c: 0});
      build_sched();
      ex_plot = 1'b0;
      ex_busy = 1'b1;
      ex_done = 1'b0;
    end else begin
      ex_plot = 1'b0;
      ex_busy = 1'b0;
      ex_done = 1'b0;
    end
  end

  // ---------------- compare process ----------------
  bit chk_en   = 1'b0;
  int done_cnt = 0;
  int dq_x[$], dq_y[$], dq_c[$];

  always @(negedge clk) begin
    if (chk_en) begin
      check("vga_plot",   32'(vga_plot),   32'(ex_plot));
      check("vga_x",      32'(vga_x),      32'(ex_x));
      check("vga_y",      32'(vga_y),      32'(ex_y));
      check("vga_c",      32'(vga_c),      32'(ex_c));
      check("busy",       32'(busy),       32'(ex_busy));
      check("frame_done", 32'(frame_done), 32'(ex_done));
      if (vga_plot === 1'b1) begin
        dq_x.push_back(int'(vga_x));
        dq_y.push_back(int'(vga_y));
        dq_c.push_back(int'(vga_c));
      end
      if (frame_done === 1'b1) done_cnt++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic clear_slots();
    obj_x = '0; obj_y = '0; obj_w = '0; obj_h = '0; obj_c = '0; obj_en = '0;
  endtask

  task automatic set_slot(input int i, input int x, input int y, input int w,
                          input int h, input int c, input bit en);
    obj_x[i*XW +: XW] = XW'(x);
    obj_y[i*YW +: YW] = YW'(y);
    obj_w[i*DW +: DW] = DW'(w);
    obj_h[i*DW +: DW] = DW'(h);
    obj_c[i*CW +: CW] = CW'(c);
    obj_en[i]         = en;
  endtask

  task automatic rand_slots();
    for (int i = 0; i < N; i++) begin
      int x, y;
      x = ($urandom_range(0, 3) == 0) ? int'($urandom_range(140, 255)) : int'($urandom_range(0, 255));
      y = ($urandom_range(0, 3) == 0) ? int'($urandom_range(110, 127)) : int'($urandom_range(0, 127));
      set_slot(i, x, y, int'($urandom_range(0, 6)), int'($urandom_range(0, 6)),
               int'($urandom_range(0, 7)), $urandom_range(0, 3) != 0);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic clear_plots();
    dq_x.delete(); dq_y.delete(); dq_c.delete();
  endtask

  // cnt = edges from the frame_start sample to the frame_done pulse.
  task automatic run_frame(input bit restart, input bit scramble, output int cnt);
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    cnt = 0;
    while (frame_done !== 1'b1 && cnt < 3000) begin
      @(posedge clk); #1;
      cnt++;
      frame_start = restart && (cnt == 2);
      if (scramble) rand_slots();
    end
    frame_start = 1'b0;
    check("frame_done_seen", 32'(frame_done), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic check_plot(input string name, input int k, input int x, input int y, input int c);
    if (k < dq_x.size()) begin
      check({name, "_x"}, 32'(dq_x[k]), 32'(x));
      check({name, "_y"}, 32'(dq_y[k]), 32'(y));
      check({name, "_c"}, 32'(dq_c[k]), 32'(c));
    end else begin
      check({name, "_present"}, 32'(dq_x.size()), 32'(k + 1));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected end of test");
    $fatal(1);
  end

  initial begin
    int cnt, d0;
    reset = 1'b0;
    frame_start = 1'b0;
    clear_slots();
    @(posedge clk); #1;
    chk_en = 1'b1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_plot", 32'(vga_plot), 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    check("rst_x", 32'(vga_x), 32'd0);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;

    // single 2x2 slot
    clear_slots();
    set_slot(0, 10, 20, 2, 2, 5, 1'b1);
    clear_plots();
    run_frame(1'b0, 1'b0, cnt);
    check("t1_len", 32'(cnt), 32'd9);
    check("t1_nplots", 32'(dq_x.size()), 32'd4);
    check_plot("t1_p0", 0, 10, 20, 5);
    check_plot("t1_p1", 1, 11, 20, 5);
    check_plot("t1_p2", 2, 10, 21, 5);
    check_plot("t1_p3", 3, 11, 21, 5);

    // slots 1 and 3 disabled, 0/2/4 are 3x1
    do_reset();
    clear_slots();
    set_slot(0, 0, 0, 3, 1, 1, 1'b1);
    set_slot(1, 60, 60, 2, 2, 3, 1'b0);
    set_slot(2, 20, 30, 3, 1, 2, 1'b1);
    set_slot(3, 70, 70, 4, 4, 6, 1'b0);
    set_slot(4, 40, 50, 3, 1, 7, 1'b1);
    clear_plots();
    run_frame(1'b0, 1'b0, cnt);
    check("t2_len", 32'(cnt), 32'd14);
    check("t2_nplots", 32'(dq_x.size()), 32'd9);
    check_plot("t2_p0", 0, 0, 0, 1);
    check_plot("t2_p3", 3, 20, 30, 2);
    check_plot("t2_p8", 8, 42, 50, 7);

    // clipping at the bottom-right corner
    do_reset();
    clear_slots();
    set_slot(0, 158, 119, 4, 2, 4, 1'b1);
    clear_plots();
    run_frame(1'b0, 1'b0, cnt);
    check("t3_len", 32'(cnt), 32'd13);
    check("t3_nplots", 32'(dq_x.size()), 32'd2);
    check_plot("t3_p0", 0, 158, 119, 4);
    check_plot("t3_p1", 1, 159, 119, 4);

    // zero width slot, frame_start while busy
    do_reset();
    clear_slots();
    set_slot(0, 3, 3, 0, 7, 2, 1'b1);
    clear_plots();
    d0 = done_cnt;
    run_frame(1'b1, 1'b0, cnt);
    repeat (10) @(posedge clk);
    #1;
    check("t4_len", 32'(cnt), 32'd5);
    check("t4_ndone", 32'(done_cnt - d0), 32'd1);
    check("t4_nplots", 32'(dq_x.size()), 32'd0);

    // reset at the third pixel, then a full frame
    do_reset();
    clear_slots();
    set_slot(0, 30, 40, 4, 2, 3, 1'b1);
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("t5_third_plot", 32'(vga_plot), 32'd1);
    reset = 1'b0;
    d0 = done_cnt;
    @(posedge clk); #1;
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_plot", 32'(vga_plot), 32'd0);
    check("t5_x", 32'(vga_x), 32'd0);
    check("t5_y", 32'(vga_y), 32'd0);
    check("t5_c", 32'(vga_c), 32'd0);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("t5_no_done", 32'(done_cnt - d0), 32'd0);
    clear_plots();
    run_frame(1'b0, 1'b0, cnt);
    check("t5_len", 32'(cnt), 32'd13);
    check("t5_nplots", 32'(dq_x.size()), 32'd8);
    check_plot("t5_p7", 7, 33, 41, 3);

`ifdef ERASE_PASS_EN
    // erase pass: slot moves from (5,5) to (6,5)
    do_reset();
    clear_slots();
    set_slot(0, 5, 5, 1, 1, 6, 1'b1);
    clear_plots();
    run_frame(1'b0, 1'b0, cnt);
    check("t7_f1_nplots", 32'(dq_x.size()), 32'd1);
    check_plot("t7_f1_p0", 0, 5, 5, 6);
    set_slot(0, 6, 5, 1, 1, 6, 1'b1);
    clear_plots();
    run_frame(1'b0, 1'b0, cnt);
    check("t7_f2_len", 32'(cnt), 32'd12);
    check("t7_f2_nplots", 32'(dq_x.size()), 32'd2);
    check_plot("t7_f2_p0", 0, 5, 5, 0);
    check_plot("t7_f2_p1", 1, 6, 5, 6);
`endif

    // randomized frames with inputs changing mid-frame
    for (int f = 0; f < 30; f++) begin
      rand_slots();
      run_frame($urandom_range(0, 1) == 1, 1'b1, cnt);
      repeat (int'($urandom_range(0, 3))) @(posedge clk);
      #1;
    end

    repeat (3) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
